// File: rtl/muldiv_unit_iter_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
// Function codes follow the RV32M funct3 encoding.
package muldiv_unit_iter_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_func_t;

   function automatic logic is_div(input mdu_func_t f);
      return (f inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU});
   endfunction

   function automatic logic is_rem(input mdu_func_t f);
      return (f inside {MDU_REM, MDU_REMU});
   endfunction

   // op1 is signed for MULH/MULHSU/DIV/REM, op2 only for MULH/DIV/REM.
   function automatic logic is_signed_op1(input mdu_func_t f);
      return (f inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
   endfunction

   function automatic logic is_signed_op2(input mdu_func_t f);
      return (f inside {MDU_MULH, MDU_DIV, MDU_REM});
   endfunction

endpackage

// File: rtl/muldiv_unit_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The slave modport is the unit side, the master modport is the pipeline side.
interface muldiv_unit_iter_if #(
   parameter int WIDTH = 32
);
   logic             flush_i;
   logic             valid_i;
   logic             ready_o;
   logic [2:0]       func_i;
   logic [WIDTH-1:0] op1_i;
   logic [WIDTH-1:0] op2_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] d_o;
   logic             div_zero_o;

   modport master (
      output flush_i, valid_i, func_i, op1_i, op2_i, ready_i,
      input  ready_o, valid_o, d_o, div_zero_o
   );

   modport slave (
      input  flush_i, valid_i, func_i, op1_i, op2_i, ready_i,
      output ready_o, valid_o, d_o, div_zero_o
   );
endinterface

// File: rtl/muldiv_unit_iter_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dividend_bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);
   logic [WIDTH:0] diff;

   // A borrow into bit WIDTH means the divisor did not fit.
   always_comb begin
      diff    = {rem_i, dividend_bit_i} - {1'b0, divisor_i};
      q_bit_o = ~diff[WIDTH];
      rem_o   = q_bit_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], dividend_bit_i};
   end

endmodule

// File: rtl/muldiv_unit_iter.sv
// Iterative RV32M multiply/divide unit: one product or quotient bit per clock,
// operating on magnitudes with the sign applied in a final FIX cycle.
module muldiv_unit_iter
   import muldiv_unit_iter_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input logic              clk_i,
   input logic              rst_n_i,
   muldiv_unit_iter_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mdu_func_t        func_q, func_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_q, neg_d;
   logic             special_q, special_d;
   logic             dz_pend_q, dz_pend_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             valid_q, valid_d;
   logic             div_zero_q, div_zero_d;

   mdu_func_t        func_in;
   logic             accept;
   logic             s1, s2;
   logic [WIDTH-1:0] abs1, abs2;
   logic             div_zero_in, ovf_in, special_in;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   div_rem;
   logic               div_qbit;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_sel, div_fix, special_res, fix_res;

   assign func_in = mdu_func_t'(bus.func_i);
   assign accept  = bus.valid_i & (state_q == S_IDLE) & ~bus.flush_i;

   // Operand conditioning at accept: magnitudes plus the special-case decode.
   always_comb begin
      s1          = is_signed_op1(func_in) & bus.op1_i[WIDTH-1];
      s2          = is_signed_op2(func_in) & bus.op2_i[WIDTH-1];
      abs1        = s1 ? -bus.op1_i : bus.op1_i;
      abs2        = s2 ? -bus.op2_i : bus.op2_i;
      div_zero_in = is_div(func_in) & (bus.op2_i == '0);
      ovf_in      = is_div(func_in) & is_signed_op2(func_in) &
                    (bus.op1_i == MIN_NEG) & (bus.op2_i == '1);
      special_in  = FAST_SPECIAL & (div_zero_in | ovf_in);
   end

   assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i          (acc_q),
      .dividend_bit_i (lo_q[WIDTH-1]),
      .divisor_i      (mcand_q),
      .rem_o          (div_rem),
      .q_bit_o        (div_qbit)
   );

   // Fast special results reuse lo_q, which then holds op1 unmodified.
   always_comb begin
      prod_fix    = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
      div_sel     = is_rem(func_q) ? acc_q : lo_q;
      div_fix     = neg_q ? -div_sel : div_sel;
      special_res = is_rem(func_q) ? (dz_pend_q ? lo_q : '0)
                                   : (dz_pend_q ? '1 : lo_q);
      if (special_q)
         fix_res = special_res;
      else if (is_div(func_q))
         fix_res = div_fix;
      else if (func_q == MDU_MUL)
         fix_res = prod_fix[WIDTH-1:0];
      else
         fix_res = prod_fix[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      func_d     = func_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      neg_d      = neg_q;
      special_d  = special_q;
      dz_pend_d  = dz_pend_q;
      d_d        = d_q;
      valid_d    = valid_q;
      div_zero_d = div_zero_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               func_d    = func_in;
               cnt_d     = '0;
               acc_d     = '0;
               special_d = special_in;
               dz_pend_d = div_zero_in;
               mcand_d   = is_div(func_in) ? abs2 : abs1;
               lo_d      = special_in ? bus.op1_i : (is_div(func_in) ? abs1 : abs2);
               // Division by zero keeps an all-ones quotient regardless of signs.
               neg_d     = is_rem(func_in) ? s1 : ((s1 ^ s2) & ~div_zero_in);
               state_d   = special_in ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (is_div(func_q)) begin
               acc_d = div_rem;
               lo_d  = {lo_q[WIDTH-2:0], div_qbit};
            end else begin
               acc_d = mul_sum[WIDTH:1];
               lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            if (cnt_q == LAST_CNT)
               state_d = S_FIX;
         end
         S_FIX: begin
            d_d        = fix_res;
            div_zero_d = dz_pend_q;
            valid_d    = 1'b1;
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (bus.ready_i) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.flush_i) begin
         state_d    = S_IDLE;
         valid_d    = 1'b0;
         div_zero_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         func_q     <= MDU_MUL;
         mcand_q    <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         neg_q      <= 1'b0;
         special_q  <= 1'b0;
         dz_pend_q  <= 1'b0;
         d_q        <= '0;
         valid_q    <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         func_q     <= func_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         neg_q      <= neg_d;
         special_q  <= special_d;
         dz_pend_q  <= dz_pend_d;
         d_q        <= d_d;
         valid_q    <= valid_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.ready_o    = (state_q == S_IDLE);
   assign bus.valid_o    = valid_q;
   assign bus.d_o        = d_q;
   assign bus.div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit_iter.sv
// Scoreboard bench for muldiv_unit_iter: three instances (32-bit fast specials,
// 32-bit iterated specials, 8-bit) driven with directed hand-computed vectors.
module tb_muldiv_unit_iter;
   import muldiv_unit_iter_pkg::*;

   typedef struct {
      int          unit;
      logic [31:0] d;
      logic        dz;
      int          lat;
      int          acc;
      int          id;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        cons_ready;
   logic [2:0]  func_s;
   logic [31:0] op1_s, op2_s;
   logic [2:0]  vin;

   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;
   int   vec_id     = 0;
   exp_t exp_q[$];

   logic [2:0]  mon_v, mon_rdy, mon_dz, prev_v;
   logic [31:0] mon_d [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_unit_iter_if #(.WIDTH(32)) bus_a ();
   muldiv_unit_iter_if #(.WIDTH(32)) bus_b ();
   muldiv_unit_iter_if #(.WIDTH(8))  bus_c ();

   muldiv_unit_iter #(.WIDTH(32), .FAST_SPECIAL(1'b1)) u_dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_a));
   muldiv_unit_iter #(.WIDTH(32), .FAST_SPECIAL(1'b0)) u_dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_b));
   muldiv_unit_iter #(.WIDTH(8),  .FAST_SPECIAL(1'b1)) u_dut_c (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_c));

   // All instances share operands, flush and consumer ready; valid_i is per unit.
   assign bus_a.flush_i = flush;  assign bus_b.flush_i = flush;  assign bus_c.flush_i = flush;
   assign bus_a.ready_i = cons_ready; assign bus_b.ready_i = cons_ready; assign bus_c.ready_i = cons_ready;
   assign bus_a.func_i = func_s;  assign bus_b.func_i = func_s;  assign bus_c.func_i = func_s;
   assign bus_a.op1_i = op1_s;    assign bus_b.op1_i = op1_s;    assign bus_c.op1_i = op1_s[7:0];
   assign bus_a.op2_i = op2_s;    assign bus_b.op2_i = op2_s;    assign bus_c.op2_i = op2_s[7:0];
   assign bus_a.valid_i = vin[0]; assign bus_b.valid_i = vin[1]; assign bus_c.valid_i = vin[2];

   assign mon_v   = {bus_c.valid_o, bus_b.valid_o, bus_a.valid_o};
   assign mon_rdy = {bus_c.ready_o, bus_b.ready_o, bus_a.ready_o};
   assign mon_dz  = {bus_c.div_zero_o, bus_b.div_zero_o, bus_a.div_zero_o};
   assign mon_d[0] = bus_a.d_o;
   assign mon_d[1] = bus_b.d_o;
   assign mon_d[2] = {24'b0, bus_c.d_o};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: latency on the rising edge of valid_o, data when the result is taken.
   always @(negedge clk) begin
      for (int u = 0; u < 3; u++) begin
         if (mon_v[u] && !prev_v[u]) begin
            if (exp_q.size() == 0 || exp_q[0].unit != u)
               checkOutput($sformatf("unexpected_valid_u%0d", u), {31'b0, mon_v[u]}, 32'd0);
            else
               checkOutput($sformatf("latency_v%0d", exp_q[0].id), cyc - exp_q[0].acc, exp_q[0].lat);
         end
         if (mon_v[u] && cons_ready && exp_q.size() != 0 && exp_q[0].unit == u) begin
            checkOutput($sformatf("d_o_v%0d", exp_q[0].id), mon_d[u], exp_q[0].d);
            checkOutput($sformatf("div_zero_v%0d", exp_q[0].id), {31'b0, mon_dz[u]}, {31'b0, exp_q[0].dz});
            void'(exp_q.pop_front());
         end
      end
      prev_v <= mon_v;
   end

   task automatic applyStimulus(input int u, input mdu_func_t f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_d,
                                input logic exp_dz, input int lat, input bit push);
      int   waited = 0;
      exp_t e;
      @(negedge clk);
      while (!mon_rdy[u] && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!mon_rdy[u]) begin
         checkOutput("ready_timeout", {31'b0, mon_rdy[u]}, 32'd1);
         return;
      end
      func_s = f; op1_s = a; op2_s = b; vin[u] = 1'b1;
      @(posedge clk);
      #1;
      vin[u] = 1'b0;
      func_s = 3'd7; op1_s = 32'hDEADBEEF; op2_s = 32'h0;
      if (push) begin
         e.unit = u; e.d = exp_d; e.dz = exp_dz; e.lat = lat; e.acc = cyc; e.id = vec_id;
         exp_q.push_back(e);
      end
      vec_id++;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checkOutput("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic watchNoValid(input string name);
      logic seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= mon_v[0];
      end
      checkOutput(name, {31'b0, seen}, 32'd0);
   endtask

   initial begin
      int          n;
      int          bad;
      logic [31:0] rec_d;
      rst_n = 1'b1; flush = 1'b0; cons_ready = 1'b1; vin = 3'b0;
      func_s = 3'd0; op1_s = '0; op2_s = '0; prev_v = 3'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready_o", {31'b0, mon_rdy[0]}, 32'd1);
      checkOutput("reset_valid_o", {29'b0, mon_v}, 32'd0);
      checkOutput("reset_d_o", mon_d[0], 32'd0);
      checkOutput("reset_div_zero_o", {29'b0, mon_dz}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Multiply family, including the busy indication during iteration.
      applyStimulus(0, MDU_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 1'b1);
      @(negedge clk);
      checkOutput("busy_ready_o", {31'b0, mon_rdy[0]}, 32'd0);
      repeat (15) @(negedge clk);
      checkOutput("busy_ready_o_mid", {31'b0, mon_rdy[0]}, 32'd0);
      waitDrain();
      applyStimulus(0, MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33, 1'b1); waitDrain();
      applyStimulus(0, MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 1'b1); waitDrain();
      applyStimulus(0, MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 1'b1); waitDrain();

      // Divide family on ordinary operands.
      applyStimulus(0, MDU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33, 1'b1); waitDrain();
      applyStimulus(0, MDU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33, 1'b1); waitDrain();
      applyStimulus(0, MDU_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1'b0, 33, 1'b1); waitDrain();
      applyStimulus(0, MDU_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 1'b0, 33, 1'b1); waitDrain();

      // Special cases: short path on unit 0, full iteration on unit 1.
      applyStimulus(0, MDU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1, 1'b1); waitDrain();
      applyStimulus(0, MDU_REMU, 32'd5,        32'd0,        32'h00000005, 1'b1, 1, 1'b1); waitDrain();
      applyStimulus(0, MDU_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, 1, 1'b1); waitDrain();
      applyStimulus(0, MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 1'b1); waitDrain();
      applyStimulus(0, MDU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 1'b1); waitDrain();
      applyStimulus(1, MDU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 33, 1'b1); waitDrain();
      applyStimulus(1, MDU_REMU, 32'd5,        32'd0,        32'h00000005, 1'b1, 33, 1'b1); waitDrain();
      applyStimulus(1, MDU_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, 33, 1'b1); waitDrain();
      applyStimulus(1, MDU_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1, 33, 1'b1); waitDrain();
      applyStimulus(1, MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 1'b1); waitDrain();
      applyStimulus(1, MDU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 1'b1); waitDrain();

      // 8-bit instance.
      applyStimulus(2, MDU_MULHU, 32'hFF, 32'hFF, 32'hFE, 1'b0, 9, 1'b1); waitDrain();
      applyStimulus(2, MDU_MUL,   32'h0D, 32'h0B, 32'h8F, 1'b0, 9, 1'b1); waitDrain();
      applyStimulus(2, MDU_DIV,   32'hF9, 32'h02, 32'hFD, 1'b0, 9, 1'b1); waitDrain();
      applyStimulus(2, MDU_REM,   32'hF9, 32'h02, 32'hFF, 1'b0, 9, 1'b1); waitDrain();

      // Back-pressure: result must hold while the consumer stalls.
      cons_ready = 1'b0;
      applyStimulus(0, MDU_MUL, 32'h12345678, 32'h10, 32'h23456780, 1'b0, 33, 1'b1);
      n = 0;
      while (!mon_v[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      rec_d = mon_d[0];
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!mon_v[0] || mon_d[0] !== rec_d || mon_rdy[0]) bad++;
      end
      checkOutput("bp_stable_cycles", bad, 32'd0);
      @(posedge clk);
      #1 cons_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("bp_ready_o_after", {31'b0, mon_rdy[0]}, 32'd1);
      checkOutput("bp_valid_o_after", {31'b0, mon_v[0]}, 32'd0);
      waitDrain();

      // Flush in the middle of iteration.
      applyStimulus(0, MDU_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_ready_o", {31'b0, mon_rdy[0]}, 32'd1);
      watchNoValid("flush_no_valid");

      // A request presented together with flush is not accepted.
      @(negedge clk);
      func_s = MDU_MUL; op1_s = 32'd2; op2_s = 32'd2; vin[0] = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 vin[0] = 1'b0; flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_blocks_accept", {31'b0, mon_rdy[0]}, 32'd1);

      // Asynchronous reset pulse while iterating.
      applyStimulus(0, MDU_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midreset_ready_o", {31'b0, mon_rdy[0]}, 32'd1);
      checkOutput("midreset_d_o", mon_d[0], 32'd0);
      checkOutput("midreset_div_zero_o", {31'b0, mon_dz[0]}, 32'd0);
      #1 rst_n = 1'b1;
      watchNoValid("midreset_no_valid");

      applyStimulus(0, MDU_MULH, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 33, 1'b1); waitDrain();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
